// File: rtl/instr_register_pkg.sv
// Types shared by the instruction register and its queue controller.
package instr_register_pkg;
  localparam int IR_DEPTH = 32;

  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [$clog2(IR_DEPTH)-1:0] address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

  // DIV/MOD by zero is refused at the queue entrance rather than stored.
  function automatic logic is_div0(opcode_t opc, operand_t b);
    return ((opc == DIV) || (opc == MOD)) && (b == '0);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last winner has top priority.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand, idx;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = ptr_q;
    found = 1'b0;
    ptr_d = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IDX_W'(N - 1)) ? '0 : cand + IDX_W'(1);
      if (en && !found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) begin
      grant[idx] = 1'b1;
      ptr_d      = idx;
    end
  end

  assign grant_idx = idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= IDX_W'(N - 1);
    else          ptr_q <= ptr_d;
  end
endmodule

// File: rtl/instr_queue_ctrl.sv
// Circular-FIFO controller in front of the 32-entry instruction register:
// arbitrates producers into the write port and feeds one consumer from the read port.
module instr_queue_ctrl
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = IR_DEPTH,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  opcode_t            req_opcode    [NUM_REQ],
  input  operand_t           req_operand_a [NUM_REQ],
  input  operand_t           req_operand_b [NUM_REQ],
  output logic               load_en,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  output address_t           write_pointer,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  output logic               out_valid,
  input  logic               out_ready,
  output instruction_t       out_instr,
  output logic [PTR_W:0]     count,
  output logic               full,
  output logic               empty,
  output logic               err_div0
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             load_en_q, load_en_d, err_div0_q, err_div0_d;
  opcode_t          opcode_q, opcode_d;
  operand_t         operand_a_q, operand_a_d, operand_b_q, operand_b_d;
  address_t         write_pointer_q, write_pointer_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [PTR_W+1:0]   occupied;
  logic               arb_en, any_grant, div0, issue, pop, commit;
  opcode_t            sel_opc;
  operand_t           sel_a, sel_b;

  // An issued-but-uncommitted load already owns a slot, so capacity counts it.
  assign occupied = {1'b0, count_q} + {{(PTR_W+1){1'b0}}, load_en_q};
  assign arb_en   = reset_n && !flush && (occupied < (PTR_W+2)'(DEPTH));

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_opc   = req_opcode[grant_idx];
  assign sel_a     = req_operand_a[grant_idx];
  assign sel_b     = req_operand_b[grant_idx];
  assign any_grant = |grant;
  assign div0      = any_grant && is_div0(sel_opc, sel_b);
  assign issue     = any_grant && !div0;
  assign pop       = (count_q != '0) && out_ready;
  assign commit    = load_en_q;

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    load_en_d       = issue;
    err_div0_d      = div0;
    opcode_d        = opcode_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    write_pointer_d = write_pointer_q;
    if (issue) begin
      opcode_d        = sel_opc;
      operand_a_d     = sel_a;
      operand_b_d     = sel_b;
      write_pointer_d = address_t'(wr_ptr_q);
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({commit, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // A load already on the bus still writes the register; its entry is simply forgotten.
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      load_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      load_en_q       <= 1'b0;
      err_div0_q      <= 1'b0;
      opcode_q        <= ZERO;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      write_pointer_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      load_en_q       <= load_en_d;
      err_div0_q      <= err_div0_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      write_pointer_q <= write_pointer_d;
    end
  end

  assign req_ready     = grant;
  assign load_en       = load_en_q;
  assign opcode        = opcode_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign write_pointer = write_pointer_q;
  assign read_pointer  = address_t'(rd_ptr_q);
  assign out_valid     = (count_q != '0);
  assign out_instr     = instruction_word;
  assign count         = count_q;
  assign full          = (count_q == (PTR_W+1)'(DEPTH));
  assign empty         = (count_q == '0);
  assign err_div0      = err_div0_q;
endmodule

// File: tb/tb_instr_queue_ctrl.sv
// Directed and random bench for instr_queue_ctrl against a queue-level reference model.
module tb_instr_queue_ctrl;
  import instr_register_pkg::*;

  localparam int NR = 2;
  localparam int IW = 1;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          reset_n, flush, out_ready;
  logic [NR-1:0] req_valid, req_ready;
  opcode_t       req_opcode [NR];
  operand_t      req_operand_a [NR];
  operand_t      req_operand_b [NR];
  logic          load_en, out_valid, full, empty, err_div0;
  opcode_t       opcode;
  operand_t      operand_a, operand_b;
  address_t      write_pointer, read_pointer;
  instruction_t  instruction_word, out_instr;
  logic [5:0]    count;

  instr_queue_ctrl #(.NUM_REQ(NR), .DEPTH(DP), .PTR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instruction_word(instruction_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .count(count), .full(full), .empty(empty), .err_div0(err_div0)
  );

  always #5 clk = ~clk;

  function automatic result_t calc(opcode_t o, operand_t a, operand_t b);
    case (o)
      PASSA:   return result_t'(a);
      PASSB:   return result_t'(b);
      ADD:     return result_t'(a) + result_t'(b);
      SUB:     return result_t'(a) - result_t'(b);
      MULT:    return result_t'(a) * result_t'(b);
      DIV:     return (b == 0) ? '0 : result_t'(a) / result_t'(b);
      MOD:     return (b == 0) ? '0 : result_t'(a) % result_t'(b);
      default: return '0;
    endcase
  endfunction

  function automatic instruction_t mk(opcode_t o, operand_t a, operand_t b);
    instruction_t r;
    r.opc = o; r.op_a = a; r.op_b = b; r.result = calc(o, a, b);
    return r;
  endfunction

  // Behavioural instruction register sitting behind the controller.
  instruction_t mem [DP];
  always @(posedge clk) if (load_en) mem[write_pointer] <= mk(opcode, operand_a, operand_b);
  assign instruction_word = mem[read_pointer];

  // Reference model state: committed FIFO contents plus the one load in flight.
  instruction_t mq[$];
  bit           pend_v, div0_prev;
  instruction_t pend_i;
  int           pend_addr, wr_idx, rd_idx, last;
  int           dut_glog[$];
  int           checks, errors;
  instruction_t exp_i;

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); pend_v = 0; div0_prev = 0; wr_idx = 0; rd_idx = 0; last = NR - 1;
  endtask

  task automatic set_req(int i, bit v, opcode_t o, int a, int b);
    req_valid[IW'(i)]     = v;
    req_opcode[IW'(i)]    = o;
    req_operand_a[IW'(i)] = a;
    req_operand_b[IW'(i)] = b;
  endtask

  task automatic rand_req(int i);
    set_req(i, 1'($urandom_range(0, 1)), opcode_t'(4'($urandom_range(0, 7))),
            int'($urandom_range(0, 50)), int'($urandom_range(0, 3)));
  endtask

  task automatic check_reset_outputs(string pfx);
    chk({pfx, "_load_en"}, 192'(load_en), 192'(0));
    chk({pfx, "_count"}, 192'(count), 192'(0));
    chk({pfx, "_empty"}, 192'(empty), 192'(1));
    chk({pfx, "_out_valid"}, 192'(out_valid), 192'(0));
    chk({pfx, "_req_ready"}, 192'(req_ready), 192'(0));
    chk({pfx, "_wp"}, 192'(write_pointer), 192'(0));
    chk({pfx, "_rp"}, 192'(read_pointer), 192'(0));
    chk({pfx, "_err_div0"}, 192'(err_div0), 192'(0));
    chk({pfx, "_opcode"}, 192'(opcode), 192'(ZERO));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock: check every output against the model mid-cycle, then advance the model.
  task automatic cycle();
    int            g, j;
    bit            pop, fl;
    logic [NR-1:0] rv;
    instruction_t  ni;
    @(negedge clk);
    chk("count", 192'(count), 192'(mq.size()));
    chk("out_valid", 192'(out_valid), 192'(mq.size() != 0));
    chk("empty", 192'(empty), 192'(mq.size() == 0));
    chk("full", 192'(full), 192'(mq.size() == DP));
    chk("read_pointer", 192'(read_pointer), 192'(rd_idx));
    chk("load_en", 192'(load_en), 192'(pend_v));
    chk("err_div0", 192'(err_div0), 192'(div0_prev));
    chk("ready_onehot", 192'($countones(req_ready) <= 1), 192'(1));
    if (mq.size() != 0) chk("out_instr", 192'(out_instr), 192'(mq[0]));
    if (pend_v) begin
      chk("write_pointer", 192'(write_pointer), 192'(pend_addr));
      chk("issue_fields", 192'({opcode, operand_a, operand_b}),
          192'({pend_i.opc, pend_i.op_a, pend_i.op_b}));
    end
    g = -1;
    if (!flush && (mq.size() + int'(pend_v)) < DP)
      for (int k = 1; k <= NR; k++) begin
        j  = (last + k) % NR;
        rv = req_valid >> j;
        if (g < 0 && rv[0]) g = j;
      end
    chk("req_ready", 192'(req_ready), (g < 0) ? 192'(0) : (192'(1) << g));
    if (req_ready[0]) dut_glog.push_back(0);
    else if (req_ready[1]) dut_glog.push_back(1);
    ni = '0;
    if (g >= 0) ni = mk(req_opcode[IW'(g)], req_operand_a[IW'(g)], req_operand_b[IW'(g)]);
    pop = (mq.size() != 0) && out_ready;
    fl  = flush;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete(); pend_v = 0; div0_prev = 0; wr_idx = 0; rd_idx = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        rd_idx = (rd_idx + 1) % DP;
      end
      if (pend_v) mq.push_back(pend_i);
      pend_v = 0; div0_prev = 0;
      if (g >= 0) begin
        last = g;
        if ((ni.opc == DIV || ni.opc == MOD) && ni.op_b == 0) div0_prev = 1;
        else begin
          pend_v = 1; pend_i = ni; pend_addr = wr_idx; wr_idx = (wr_idx + 1) % DP;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0; req_valid = '0;
    for (int i = 0; i < NR; i++) set_req(i, 0, ZERO, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    do_reset();

    // Single ADD flows through with two-edge latency.
    set_req(0, 1, ADD, 3, 4);
    cycle();
    set_req(0, 0, ZERO, 0, 0);
    chk("t1_load_en", 192'(load_en), 192'(1));
    chk("t1_wp", 192'(write_pointer), 192'(0));
    cycle();
    exp_i.opc = ADD; exp_i.op_a = 3; exp_i.op_b = 4; exp_i.result = 7;
    chk("t1_out_valid", 192'(out_valid), 192'(1));
    chk("t1_count", 192'(count), 192'(1));
    chk("t1_out_instr", 192'(out_instr), 192'(exp_i));
    cycle();

    // Two requesters contend: strict alternation starting with 0.
    do_reset();
    out_ready = 1'b1;
    set_req(0, 1, ADD, 10, 1);
    set_req(1, 1, SUB, 20, 2);
    dut_glog.delete();
    repeat (4) cycle();
    req_valid = '0;
    chk("t2_ngrants", 192'(dut_glog.size()), 192'(4));
    if (dut_glog.size() == 4) begin
      chk("t2_g0", 192'(dut_glog[0]), 192'(0));
      chk("t2_g1", 192'(dut_glog[1]), 192'(1));
      chk("t2_g2", 192'(dut_glog[2]), 192'(0));
      chk("t2_g3", 192'(dut_glog[3]), 192'(1));
    end
    repeat (3) cycle();

    // Fill to capacity, then one pop lets a single grant through a cycle later.
    do_reset();
    out_ready = 1'b0;
    set_req(0, 1, MULT, 6, 7);
    repeat (40) cycle();
    chk("t3_full", 192'(full), 192'(1));
    chk("t3_count", 192'(count), 192'(32));
    chk("t3_ready", 192'(req_ready), 192'(0));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    chk("t3_wrap_load", 192'(load_en), 192'(1));
    chk("t3_wrap_wp", 192'(write_pointer), 192'(0));
    req_valid = '0;
    cycle();

    // Steady push/pop at depth 5 walks both pointers around the ring.
    do_reset();
    out_ready = 1'b0;
    set_req(0, 1, ADD, 1, 1);
    repeat (5) cycle();
    req_valid = '0;
    repeat (2) cycle();
    chk("t4_prefill", 192'(count), 192'(5));
    set_req(0, 1, PASSA, 100, 0);
    cycle();
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      set_req(0, 1, ADD, n, 2 * n);
      cycle();
      chk("t4_count", 192'(count), 192'(5));
    end
    req_valid = '0;
    repeat (8) cycle();

    // DIV by zero is swallowed; the following MOD takes the same slot.
    do_reset();
    out_ready = 1'b0;
    set_req(0, 1, ADD, 2, 2);
    cycle();
    set_req(0, 0, ZERO, 0, 0);
    cycle();
    set_req(0, 1, DIV, 9, 0);
    cycle();
    chk("t5_err", 192'(err_div0), 192'(1));
    chk("t5_load_en", 192'(load_en), 192'(0));
    chk("t5_count", 192'(count), 192'(1));
    set_req(0, 1, MOD, 9, 4);
    cycle();
    set_req(0, 0, ZERO, 0, 0);
    chk("t5_err_clear", 192'(err_div0), 192'(0));
    chk("t5_mod_load", 192'(load_en), 192'(1));
    chk("t5_mod_wp", 192'(write_pointer), 192'(1));
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    exp_i.opc = MOD; exp_i.op_a = 9; exp_i.op_b = 4; exp_i.result = 1;
    chk("t5_mod_head", 192'(out_instr), 192'(exp_i));
    cycle();

    // Flush with seven entries and a load in flight.
    do_reset();
    out_ready = 1'b0;
    set_req(0, 1, SUB, 50, 5);
    repeat (8) cycle();
    chk("t6_pre_count", 192'(count), 192'(7));
    chk("t6_pre_load", 192'(load_en), 192'(1));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t6_count", 192'(count), 192'(0));
    chk("t6_empty", 192'(empty), 192'(1));
    chk("t6_rp", 192'(read_pointer), 192'(0));
    chk("t6_load", 192'(load_en), 192'(0));
    cycle();
    chk("t6_wp_restart", 192'(write_pointer), 192'(0));
    out_ready = 1'b1;
    repeat (4) cycle();

    // Asynchronous reset in the middle of traffic.
    for (int n = 0; n < 6; n++) begin
      set_req(0, 1, ADD, n, 1);
      set_req(1, 1, PASSB, 0, n);
      out_ready = 1'(n & 1);
      cycle();
    end
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async");
    model_reset();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Random traffic, occasional flush.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NR; i++) rand_req(i);
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 63) == 0);
      if (n > 700 && n < 900) out_ready = 1'b0;
      cycle();
    end
    flush = 1'b0;
    req_valid = '0;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
